// File: rtl/y86_pipe_ctrl_if.sv
// Signal bundle between the Y86 pipeline datapath (master) and the control unit (slave).
// When Y86_PIPE_PERF_EN is defined, the bundle also carries the performance counters.
interface y86_pipe_ctrl_if;
  logic [3:0]  D_icode;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [3:0]  E_icode;
  logic [3:0]  E_dstM;
  logic        e_Cnd;
  logic [3:0]  W_icode;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic        E_bubble;
  logic        M_bubble;
  logic        W_stall;
  logic [2:0]  ctrl_state;
`ifdef Y86_PIPE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bubble_cnt;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, W_icode,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, ctrl_state,
    input  perf_stall_cnt, perf_bubble_cnt
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, W_icode,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, ctrl_state,
    output perf_stall_cnt, perf_bubble_cnt
  );
`else
  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, W_icode,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, ctrl_state
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, W_icode,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, ctrl_state
  );
`endif
endinterface

// File: rtl/y86_pipe_ctrl.sv
// Y86 pipeline hazard control: load-use stall, mispredict squash, RET fetch hold, HALT freeze.
// Optional feature macro: Y86_PIPE_PERF_EN adds 32-bit stall/bubble performance counters.
module y86_pipe_ctrl #(
  parameter int RET_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  y86_pipe_ctrl_if.slave ctrl
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam int CW = (RET_WAIT < 2) ? 1 : $clog2(RET_WAIT + 1);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_RETW   = 3'd1,
    ST_HALTED = 3'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic load_use;
  logic mispred;
  logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall;

  assign load_use = ((ctrl.E_icode == I_MRMOVL) || (ctrl.E_icode == I_POPL)) &&
                    (ctrl.E_dstM != R_NONE) &&
                    ((ctrl.E_dstM == ctrl.d_srcA) || (ctrl.E_dstM == ctrl.d_srcB));

  assign mispred = (ctrl.E_icode == I_JXX) && !ctrl.e_Cnd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = ST_RUN;
    cnt_d    = cnt_q;
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_stall  = 1'b0;

    case (state_q)
      ST_RUN: begin
        state_d = ST_RUN;
        if (load_use) begin
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          e_bubble = 1'b1;
        end else if (mispred) begin
          // A RET sitting in decode is on the wrong path here and is squashed.
          d_bubble = 1'b1;
          e_bubble = 1'b1;
        end else if (ctrl.D_icode == I_RET) begin
          f_stall  = 1'b1;
          d_bubble = 1'b1;
          state_d  = ST_RETW;
          cnt_d    = CW'(RET_WAIT - 1);
        end
      end

      ST_RETW: begin
        f_stall  = 1'b1;
        d_bubble = 1'b1;
        // The RUN cycle that saw the RET is the first hold cycle, so RETW
        // exits on the edge where the counter reaches zero.
        cnt_d    = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        state_d  = (cnt_d == '0) ? ST_RUN : ST_RETW;
      end

      ST_HALTED: begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        w_stall  = 1'b1;
        m_bubble = 1'b1;
        state_d  = ST_HALTED;
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    if (ctrl.W_icode == I_HALT) begin
      state_d = ST_HALTED;
      cnt_d   = '0;
    end
  end

  // Reset forces quiet outputs even while combinational hazard inputs are active.
  assign ctrl.F_stall    = f_stall  & ~reset;
  assign ctrl.D_stall    = d_stall  & ~reset;
  assign ctrl.D_bubble   = d_bubble & ~reset;
  assign ctrl.E_bubble   = e_bubble & ~reset;
  assign ctrl.M_bubble   = m_bubble & ~reset;
  assign ctrl.W_stall    = w_stall  & ~reset;
  assign ctrl.ctrl_state = reset ? 3'd0 : state_q;

`ifdef Y86_PIPE_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_bubble_d = perf_bubble_q;
    if (state_q != ST_HALTED) begin
      if (f_stall)
        perf_stall_d = perf_stall_q + 32'd1;
      if (d_bubble || e_bubble)
        perf_bubble_d = perf_bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign ctrl.perf_stall_cnt  = perf_stall_q;
  assign ctrl.perf_bubble_cnt = perf_bubble_q;
`endif

  a_stall_xor_bubble: assert property (@(posedge clk) disable iff (reset)
    !(d_stall && d_bubble));
  a_dstall_needs_fstall: assert property (@(posedge clk) disable iff (reset)
    d_stall |-> f_stall);
  a_halted_sticky: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_HALTED) |=> (state_q == ST_HALTED));

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Directed bench for y86_pipe_ctrl: per-scenario tasks, queue scoreboard of expected control vectors.
module tb_y86_pipe_ctrl;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  // {ctrl_state, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  localparam logic [8:0] V_IDLE = 9'b000_000000;
  localparam logic [8:0] V_LU   = 9'b000_110100;
  localparam logic [8:0] V_MISP = 9'b000_001100;
  localparam logic [8:0] V_RET  = 9'b000_101000;
  localparam logic [8:0] V_RETW = 9'b001_101000;
  localparam logic [8:0] V_HALT = 9'b010_110011;

  typedef struct packed {
    logic [3:0] d_icode;
    logic [3:0] srca;
    logic [3:0] srcb;
    logic [3:0] e_icode;
    logic [3:0] e_dstm;
    logic       e_cnd;
    logic [3:0] w_icode;
    logic [8:0] exp;
  } row_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] exp_q[$];

  y86_pipe_ctrl_if ctrl();

  y86_pipe_ctrl #(.RET_WAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input logic [3:0] d, input logic [3:0] sa, input logic [3:0] sb,
                              input logic [3:0] e, input logic [3:0] ed, input logic c,
                              input logic [3:0] w, input logic [8:0] x);
    row_t r;
    r.d_icode = d; r.srca = sa; r.srcb = sb; r.e_icode = e;
    r.e_dstm = ed; r.e_cnd = c; r.w_icode = w; r.exp = x;
    return r;
  endfunction

  function automatic logic [8:0] obs_vec();
    return {ctrl.ctrl_state, ctrl.F_stall, ctrl.D_stall, ctrl.D_bubble,
            ctrl.E_bubble, ctrl.M_bubble, ctrl.W_stall};
  endfunction

  task automatic drive(input row_t r);
    ctrl.D_icode = r.d_icode;
    ctrl.d_srcA  = r.srca;
    ctrl.d_srcB  = r.srcb;
    ctrl.E_icode = r.e_icode;
    ctrl.E_dstM  = r.e_dstm;
    ctrl.e_Cnd   = r.e_cnd;
    ctrl.W_icode = r.w_icode;
    exp_q.push_back(r.exp);
  endtask

  task automatic test_reset();
    logic [8:0] got, want;
    reset = 1'b1;
    drive(mk(I_RET, 4'h3, R_NONE, I_MRMOVL, 4'h3, 1'b1, I_NOP, V_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = obs_vec(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", got, want);
    end
`ifdef Y86_PIPE_PERF_EN
    checks++;
    if (ctrl.perf_stall_cnt !== 32'd0 || ctrl.perf_bubble_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0",
                         ctrl.perf_stall_cnt, ctrl.perf_bubble_cnt);
    end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_no_hazard();
    row_t rows[5];
    logic [8:0] got, want;
    rows = '{mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP, V_IDLE),
             mk(I_OPL, 4'h3,   4'h2,   I_OPL,    4'h3,   1'b1, I_NOP, V_IDLE),
             mk(I_OPL, 4'h1,   R_NONE, I_MRMOVL, R_NONE, 1'b1, I_NOP, V_IDLE),
             mk(I_OPL, 4'h4,   4'h5,   I_JXX,    R_NONE, 1'b1, I_NOP, V_IDLE),
             mk(I_OPL, 4'h2,   4'h6,   I_POPL,   4'h5,   1'b1, I_NOP, V_IDLE)};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = obs_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL no_hazard[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[4];
    logic [8:0] got, want;
    rows = '{mk(I_OPL, 4'h3,   R_NONE, I_MRMOVL, 4'h3,   1'b1, I_NOP, V_LU),
             mk(I_OPL, 4'h1,   4'h7,   I_POPL,   4'h7,   1'b1, I_NOP, V_LU),
             mk(I_OPL, R_NONE, R_NONE, I_MRMOVL, R_NONE, 1'b1, I_NOP, V_IDLE),
             mk(I_OPL, 4'h1,   4'h7,   I_NOP,    R_NONE, 1'b1, I_NOP, V_IDLE)};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = obs_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL load_use[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ret();
    row_t rows[5];
    logic [8:0] got, want;
    rows = '{mk(I_RET, R_NONE, R_NONE, I_NOP, R_NONE, 1'b1, I_NOP, V_RET),
             mk(I_NOP, R_NONE, R_NONE, I_NOP, R_NONE, 1'b1, I_NOP, V_RETW),
             mk(I_NOP, R_NONE, R_NONE, I_NOP, R_NONE, 1'b1, I_NOP, V_RETW),
             mk(I_NOP, R_NONE, R_NONE, I_NOP, R_NONE, 1'b1, I_NOP, V_IDLE),
             mk(I_NOP, R_NONE, R_NONE, I_NOP, R_NONE, 1'b1, I_NOP, V_IDLE)};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = obs_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL ret[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    row_t rows[7];
    logic [8:0] got, want;
    rows = '{mk(I_RET, R_NONE, R_NONE, I_JXX,    R_NONE, 1'b0, I_NOP, V_MISP),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP, V_IDLE),
             mk(I_RET, 4'h3,   R_NONE, I_MRMOVL, 4'h3,   1'b1, I_NOP, V_LU),
             mk(I_RET, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP, V_RET),
             mk(I_NOP, R_NONE, R_NONE, I_JXX,    R_NONE, 1'b0, I_NOP, V_RETW),
             mk(I_NOP, 4'h2,   R_NONE, I_POPL,   4'h2,   1'b1, I_NOP, V_RETW),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP, V_IDLE)};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = obs_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL priority[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    row_t rows[8];
    logic [8:0] got, want;
    rows = '{mk(I_RET, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_RET),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_RETW),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_HALT, V_RETW),
             mk(I_NOP, 4'h3,   R_NONE, I_MRMOVL, 4'h3,   1'b1, I_NOP,  V_HALT),
             mk(I_RET, R_NONE, R_NONE, I_JXX,    R_NONE, 1'b0, I_NOP,  V_HALT),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_HALT),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_HALT),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_HALT)};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = obs_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL halt[%0d]: got %b want %b", i, got, want);
      end
      @(posedge clk); #1;
    end
    // Reset asserted between edges must clear the HALTED state without a clock.
    @(negedge clk); #2;
    drive(mk(I_RET, 4'h3, R_NONE, I_MRMOVL, 4'h3, 1'b1, I_NOP, V_IDLE));
    reset = 1'b1;
    #1;
    got = obs_vec(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL halt_async_reset: got %b want %b", got, want);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(mk(I_NOP, R_NONE, R_NONE, I_JXX, R_NONE, 1'b0, I_HALT, V_MISP));
    @(negedge clk);
    got = obs_vec(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL halt_from_run: got %b want %b", got, want);
    end
    @(posedge clk); #1;
    drive(mk(I_NOP, R_NONE, R_NONE, I_NOP, R_NONE, 1'b1, I_NOP, V_HALT));
    @(negedge clk);
    got = obs_vec(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL halt_entered: got %b want %b", got, want);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(mk(I_NOP, R_NONE, R_NONE, I_NOP, R_NONE, 1'b1, I_NOP, V_IDLE));
    @(negedge clk);
    got = obs_vec(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL halt_after_reset: got %b want %b", got, want);
    end
    @(posedge clk); #1;
  endtask

`ifdef Y86_PIPE_PERF_EN
  task automatic test_perf();
    row_t rows[8];
    logic [8:0] got, want;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rows = '{mk(I_OPL, 4'h3,   R_NONE, I_MRMOVL, 4'h3,   1'b1, I_NOP,  V_LU),
             mk(I_RET, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_RET),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_RETW),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_RETW),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_IDLE),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_HALT, V_IDLE),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_HALT),
             mk(I_NOP, R_NONE, R_NONE, I_NOP,    R_NONE, 1'b1, I_NOP,  V_HALT)};
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = obs_vec(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL perf_seq[%0d]: got %b want %b", i, got, want);
      end
      if (i == 4) begin
        checks++;
        if (ctrl.perf_stall_cnt !== 32'd4 || ctrl.perf_bubble_cnt !== 32'd4) begin
          errors++; $display("FAIL perf_counts: got %0d/%0d want 4/4",
                             ctrl.perf_stall_cnt, ctrl.perf_bubble_cnt);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ctrl.perf_stall_cnt !== 32'd4 || ctrl.perf_bubble_cnt !== 32'd4) begin
      errors++; $display("FAIL perf_halted_frozen: got %0d/%0d want 4/4",
                         ctrl.perf_stall_cnt, ctrl.perf_bubble_cnt);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_no_hazard();
    test_load_use();
    test_ret();
    test_priority();
    test_halt();
`ifdef Y86_PIPE_PERF_EN
    test_perf();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_pipe_ctrl.md
Y86_PIPE_CTRL -- requirements
Module: y86_pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: D_icode  in  4  icode in decode; d_srcA, d_srcB  in  4 each  decode source regs (R_NONE = 4'hF).
REQ-004 SHALL have ports: E_icode, E_dstM  in  4 each  execute-stage icode and load destination; e_Cnd  in  1  execute condition result.
REQ-005 SHALL have ports: W_icode  in  4  write-back icode.
REQ-006 SHALL have ports: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline-register controls.
REQ-007 SHALL have ports: ctrl_state  out  3  current FSM state encoding.
REQ-008 SHALL have ports: perf_stall_cnt, perf_bubble_cnt  out  32 each  present only under Configuration.
REQ-009 SHALL use parameter RET_WAIT, default 3, number of cycles the fetch is held after RET leaves decode.

Function
REQ-010 SHALL implement FSM states RUN=0, RETW=1, HALTED=2; the remaining encodings SHALL go to RUN on the next edge.
REQ-011 SHALL compute load_use = (E_icode==I_MRMOVL or I_POPL) and E_dstM!=R_NONE and (E_dstM==d_srcA or E_dstM==d_srcB), combinationally.
REQ-012 SHALL compute mispred = (E_icode==I_JXX) and !e_Cnd, combinationally.
REQ-013 In RUN with load_use: F_stall=1, D_stall=1, E_bubble=1, all other outputs 0, and the state SHALL stay RUN.
REQ-014 In RUN with mispred and no load_use: D_bubble=1, E_bubble=1, and F is not stalled.
REQ-015 In RUN with D_icode==I_RET, no load_use, no mispred: F_stall=1, D_bubble=1, and the FSM SHALL go to RETW with counter=RET_WAIT-1.
REQ-016 Priority in RUN: load_use > mispred > RET; a RET in decode together with mispred SHALL be squashed (no RETW entry).
REQ-017 In RETW: F_stall=1, D_bubble=1; counter decrements each cycle; at counter==0 the FSM SHALL return to RUN on the next edge.
REQ-018 Controls SHALL be combinational from state and inputs, so they take effect at the same edge they are evaluated for (zero latency).
REQ-019 W_icode==I_HALT in any state SHALL move the FSM to HALTED on the next edge, overriding RETW.
REQ-020 In HALTED: F_stall=D_stall=W_stall=1, M_bubble=1, other outputs 0; HALTED is left only by reset.
REQ-021 In RUN with no hazard, all control outputs SHALL be 0.

Reset
REQ-022 On reset assertion: state=RUN, RETW counter=0, perf counters=0, asynchronously, without waiting for clk.
REQ-023 While reset is high, all control outputs SHALL be 0 and ctrl_state SHALL be 0, including reset mid-RETW or in HALTED.

Configuration
REQ-024 Macro Y86_PIPE_PERF_EN SHALL gate the performance counters.
REQ-025 With Y86_PIPE_PERF_EN defined: perf_stall_cnt increments each clk with F_stall=1, perf_bubble_cnt increments each clk with E_bubble=1 or D_bubble=1, both 32-bit wrap-around; HALTED cycles SHALL NOT count.
REQ-026 Without Y86_PIPE_PERF_EN: the perf ports and counter registers SHALL be absent; all other behaviour is unchanged.

Verification
REQ-027 Load-use: E_icode=I_MRMOVL, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1 for that cycle; state stays RUN.
REQ-028 Load-use with E_dstM=4'hF, d_srcB=4'hF -> no stall, all controls 0.
REQ-029 RET: D_icode=I_RET for one cycle then I_NOP -> F_stall=D_bubble=1 for exactly 3 consecutive cycles (RET_WAIT=3), then RUN with controls 0.
REQ-030 Mispredict+RET: E_icode=I_JXX, e_Cnd=0, D_icode=I_RET -> D_bubble=E_bubble=1, F_stall=0, no RETW entry.
REQ-031 Halt during RETW: W_icode=I_HALT on the 2nd RETW cycle -> next state HALTED (ctrl_state=2), outputs held; reset pulse -> RUN, controls 0.
REQ-032 With Y86_PIPE_PERF_EN: one load-use followed by one RET -> perf_stall_cnt=4, perf_bubble_cnt=4.
